id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pkg.sv | 69 ++++++
 rtl/regfile_scb.sv | 58 +++++
 rtl/id_pipe.sv | 110 +++++++++++
 tb/tb_id_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage.
// Holds opcode constants, instruction class encoding, ctrl bit indices
// and helper functions for class lookup, ctrl vector and rd-write test.
package id_pkg;

  localparam int W_OP   = 7;
  localparam int W_CTRL = 7;

  localparam logic [W_OP-1:0] OP_ADD     = 7'b0000000;
  localparam logic [W_OP-1:0] OP_INTE_NW = 7'b0000100;  // inte op that leaves rd untouched
  localparam logic [W_OP-1:0] OP_LD      = 7'b0011000;
  localparam logic [W_OP-1:0] OP_ST      = 7'b0011001;

  // ctrl_o = {inte, logic, shift, ld, st, br, und}
  localparam int CTRL_INTE  = 6;
  localparam int CTRL_LOGIC = 5;
  localparam int CTRL_SHIFT = 4;
  localparam int CTRL_LD    = 3;
  localparam int CTRL_ST    = 2;
  localparam int CTRL_BR    = 1;
  localparam int CTRL_UND   = 0;

  typedef enum logic [2:0] {
    CL_INTE, CL_LOGIC, CL_SHIFT, CL_SET, CL_LD, CL_ST, CL_BR, CL_UND
  } iclass_t;

  function automatic iclass_t op_class(input logic [W_OP-1:0] op);
    iclass_t c;
    casez (op)
      7'b0000???:                        c = CL_INTE;
      7'b0001000, 7'b0001001, 7'b0001010,
      7'b0001100, 7'b0001101:            c = CL_SHIFT;
      7'b00100??:                        c = CL_LOGIC;
      7'b001011?:                        c = CL_SET;
      OP_LD:                             c = CL_LD;
      OP_ST:                             c = CL_ST;
      7'b00111??:                        c = CL_BR;
      default:                           c = CL_UND;
    endcase
    return c;
  endfunction

  // set class has no ctrl bit of its own
  function automatic logic [W_CTRL-1:0] ctrl_bits(input iclass_t c);
    logic [W_CTRL-1:0] v;
    v = '0;
    case (c)
      CL_INTE:  v[CTRL_INTE]  = 1'b1;
      CL_LOGIC: v[CTRL_LOGIC] = 1'b1;
      CL_SHIFT: v[CTRL_SHIFT] = 1'b1;
      CL_LD:    v[CTRL_LD]    = 1'b1;
      CL_ST:    v[CTRL_ST]    = 1'b1;
      CL_BR:    v[CTRL_BR]    = 1'b1;
      CL_UND:   v[CTRL_UND]   = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic logic writes_rd(input logic [W_OP-1:0] op, input iclass_t c);
    case (c)
      CL_INTE:                    return op != OP_INTE_NW;
      CL_SHIFT, CL_LOGIC, CL_SET,
      CL_LD:                      return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_scb.sv
// Register file with per-register busy scoreboard.
// Ports: two read ports (ra_a/ra_b -> rdata_a/rdata_b, busy_a/busy_b),
// one write port (we/wa/wdata, which also clears busy), a busy-set port
// (set_en/set_r) and an extra busy-clear port (clr_en/clr_r).
// A write in the same cycle as a read is bypassed to the read data and
// masks the busy bit; a set on the written register wins over the clear.
module regfile_scb
  import id_pkg::*;
#(
  parameter int W_DATA  = 32,
  parameter int N_REG   = 16,
  parameter int W_RADDR = $clog2(N_REG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_RADDR-1:0] ra_a,
  input  logic [W_RADDR-1:0] ra_b,
  output logic [W_DATA-1:0]  rdata_a,
  output logic [W_DATA-1:0]  rdata_b,
  output logic               busy_a,
  output logic               busy_b,
  input  logic               we,
  input  logic [W_RADDR-1:0] wa,
  input  logic [W_DATA-1:0]  wdata,
  input  logic               set_en,
  input  logic [W_RADDR-1:0] set_r,
  input  logic               clr_en,
  input  logic [W_RADDR-1:0] clr_r
);

  logic [N_REG-1:0][W_DATA-1:0] rf;
  logic [N_REG-1:0]             busy;

  logic hit_a, hit_b;
  assign hit_a   = we && (wa == ra_a);
  assign hit_b   = we && (wa == ra_b);
  assign rdata_a = hit_a ? wdata : rf[ra_a];
  assign rdata_b = hit_b ? wdata : rf[ra_b];
  assign busy_a  = busy[ra_a] & ~hit_a;
  assign busy_b  = busy[ra_b] & ~hit_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf   <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < N_REG; i++) begin
        if (we && wa == W_RADDR'(i))
          rf[i] <= wdata;
        if (set_en && set_r == W_RADDR'(i))
          busy[i] <= 1'b1;
        else if ((we && wa == W_RADDR'(i)) || (clr_en && clr_r == W_RADDR'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/id_pipe.sv
// Instruction decode stage: decodes class/immediate, reads operands with
// write-back bypass, stalls on scoreboard hazards and presents a one-deep
// valid/ready output bundle to execute.
// Ports: in_valid/in_ready/inst_i/pc_value_i from fetch; wb_i/wb_r_i/
// wb_data_i write-back; flush_i kill; out_valid/out_ready handshake with
// ctrl_o, rd/rs/imm values, immf_o, pc_value_o, opcode_o, rd_addr_o;
// stall_o = in_valid & ~in_ready.
module id_pipe
  import id_pkg::*;
#(
  parameter int W_DATA  = 32,
  parameter int N_REG   = 16,
  parameter int W_RADDR = $clog2(N_REG),
  parameter int W_PC    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst_i,
  input  logic [W_PC-1:0]    pc_value_i,
  input  logic               wb_i,
  input  logic [W_RADDR-1:0] wb_r_i,
  input  logic [W_DATA-1:0]  wb_data_i,
  input  logic               flush_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_CTRL-1:0]  ctrl_o,
  output logic [W_DATA-1:0]  rd_value_o,
  output logic [W_DATA-1:0]  rs_value_o,
  output logic [W_DATA-1:0]  imm_value_o,
  output logic               immf_o,
  output logic [W_PC-1:0]    pc_value_o,
  output logic [W_OP-1:0]    opcode_o,
  output logic [W_RADDR-1:0] rd_addr_o,
  output logic               stall_o
);

  logic [W_OP-1:0]    op;
  logic [W_RADDR-1:0] rd, rs;
  logic [15:0]        imm;
  iclass_t            cls;
  logic               wr, hazard, issue, out_wr;
  logic [W_DATA-1:0]  imm_ext, rd_val, rs_val;
  logic               busy_rd, busy_rs;

  assign op  = inst_i[31:25];
  assign rd  = W_RADDR'(inst_i[23:20]);
  assign rs  = W_RADDR'(inst_i[19:16]);
  assign imm = inst_i[15:0];
  assign cls = op_class(op);
  assign wr  = writes_rd(op, cls);

  assign imm_ext = (cls == CL_SHIFT) ? {{(W_DATA-16){1'b0}}, imm}
                                     : {{(W_DATA-16){imm[15]}}, imm};

  // rd is checked as a source too, so WAW and RAW both stall
  assign hazard   = busy_rd | busy_rs;
  assign in_ready = ~flush_i & ~hazard & (~out_valid | out_ready);
  assign issue    = in_valid & in_ready;
  assign stall_o  = in_valid & ~in_ready;

  regfile_scb #(.W_DATA(W_DATA), .N_REG(N_REG), .W_RADDR(W_RADDR)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_a    (rd),
    .ra_b    (rs),
    .rdata_a (rd_val),
    .rdata_b (rs_val),
    .busy_a  (busy_rd),
    .busy_b  (busy_rs),
    .we      (wb_i),
    .wa      (wb_r_i),
    .wdata   (wb_data_i),
    .set_en  (issue & wr),
    .set_r   (rd),
    // a flushed bundle never writes back, so release its destination
    .clr_en  (flush_i & out_valid & out_wr),
    .clr_r   (rd_addr_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_wr      <= 1'b0;
      ctrl_o      <= '0;
      rd_value_o  <= '0;
      rs_value_o  <= '0;
      imm_value_o <= '0;
      immf_o      <= 1'b0;
      pc_value_o  <= '0;
      opcode_o    <= '0;
      rd_addr_o   <= '0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_wr      <= wr;
      ctrl_o      <= ctrl_bits(cls);
      rd_value_o  <= rd_val;
      rs_value_o  <= rs_val;
      imm_value_o <= imm_ext;
      immf_o      <= inst_i[24];
      pc_value_o  <= pc_value_i;
      opcode_o    <= op;
      rd_addr_o   <= rd;
    end else if (flush_i || out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
module tb_id_pipe;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] inst;
  logic [15:0] pc;
  logic        wb;
  logic [3:0]  wb_r;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [6:0]  ctrl;
  logic [31:0] rd_value, rs_value, imm_value;
  logic        immf;
  logic [15:0] pc_out;
  logic [6:0]  opcode;
  logic [3:0]  rd_addr;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst), .pc_value_i(pc),
    .wb_i(wb), .wb_r_i(wb_r), .wb_data_i(wb_data),
    .flush_i(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_o(ctrl), .rd_value_o(rd_value), .rs_value_o(rs_value),
    .imm_value_o(imm_value), .immf_o(immf), .pc_value_o(pc_out),
    .opcode_o(opcode), .rd_addr_o(rd_addr), .stall_o(stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic f,
                                     input logic [3:0] d, input logic [3:0] s,
                                     input logic [15:0] im);
    return {op, f, d, s, im};
  endfunction

  logic [6:0] tbl_op   [6] = '{7'b0000100, 7'b0011001, 7'b0011110,
                               7'b1111111, 7'b0001011, 7'b0010100};
  logic [6:0] tbl_ctrl [6] = '{7'h40, 7'h04, 7'h02, 7'h01, 7'h01, 7'h01};

  initial begin
    rst = 1'b0; in_valid = 1'b0; inst = '0; pc = '0; wb = 1'b0; wb_r = '0;
    wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_rd_value", rd_value, 0);
    chk("rst_imm", imm_value, 0);
    chk("rst_pc", 32'(pc_out), 0);

    // issue, then reset mid-operation
    rst = 1'b1; in_valid = 1'b1; inst = mk(OP_ADD, 0, 1, 2, 16'h0005); pc = 16'h0010;
    #1 chk("first_in_ready", 32'(in_ready), 1);
    tick();
    chk("first_valid", 32'(out_valid), 1);
    chk("first_ctrl", 32'(ctrl), 32'h40);
    chk("first_imm", imm_value, 32'h5);
    chk("first_pc", 32'(pc_out), 32'h10);
    chk("first_rd_addr", 32'(rd_addr), 1);
    in_valid = 1'b0; rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ctrl", 32'(ctrl), 0);
    chk("arst_pc", 32'(pc_out), 0);
    chk("arst_imm", imm_value, 0);
    tick();
    rst = 1'b1; in_valid = 1'b1; inst = mk(OP_ADD, 0, 4, 1, 16'h0);
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);
    chk("post_rst_stall", 32'(stall), 0);
    tick();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_rd_addr", 32'(rd_addr), 4);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 0);

    // RAW hazard on r3 resolved by write-back bypass
    in_valid = 1'b1; inst = mk(OP_ADD, 0, 3, 0, 16'h0);
    #1 chk("raw_issue_ready", 32'(in_ready), 1);
    tick();
    inst = mk(OP_ADD, 0, 6, 3, 16'h0);
    #1 chk("raw_stall0", 32'(stall), 1);
    tick();
    chk("raw_stall1", 32'(stall), 1);
    chk("raw_drained", 32'(out_valid), 0);
    wb = 1'b1; wb_r = 4'd3; wb_data = 32'h1234;
    #1;
    chk("raw_wb_ready", 32'(in_ready), 1);
    chk("raw_wb_stall", 32'(stall), 0);
    tick();
    wb = 1'b0;
    chk("raw_rs_value", rs_value, 32'h1234);
    chk("raw_valid", 32'(out_valid), 1);
    chk("raw_rd_addr", 32'(rd_addr), 6);

    // backpressure for three cycles
    out_ready = 1'b0; inst = mk(OP_ADD, 0, 7, 0, 16'h0); pc = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_rd_addr", 32'(rd_addr), 6);
      chk("bp_rs_value", rs_value, 32'h1234);
      chk("bp_pc", 32'(pc_out), 32'h10);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    chk("bp_next_rd_addr", 32'(rd_addr), 7);
    chk("bp_next_pc", 32'(pc_out), 32'h20);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // flush of a held ld r5 releases busy[r5]
    in_valid = 1'b1; inst = mk(OP_LD, 0, 5, 0, 16'h0);
    tick();
    chk("ld_valid", 32'(out_valid), 1);
    chk("ld_ctrl", 32'(ctrl), 32'h08);
    out_ready = 1'b0; inst = mk(OP_ADD, 0, 8, 5, 16'h0);
    #1 chk("ld_use_stall", 32'(stall), 1);
    flush = 1'b1;
    #1 chk("flush_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    #1;
    chk("post_flush_ready", 32'(in_ready), 1);
    chk("post_flush_stall", 32'(stall), 0);
    tick();
    chk("post_flush_issue", 32'(out_valid), 1);
    chk("post_flush_rd_addr", 32'(rd_addr), 8);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // immediate extension
    in_valid = 1'b1; inst = mk(7'b0001000, 0, 9, 0, 16'h8000);
    tick();
    chk("shift_imm", imm_value, 32'h0000_8000);
    chk("shift_ctrl", 32'(ctrl), 32'h10);
    inst = mk(OP_ADD, 0, 10, 0, 16'h8000);
    #1 chk("add_imm_ready", 32'(in_ready), 1);
    tick();
    chk("add_imm", imm_value, 32'hFFFF_8000);
    in_valid = 1'b0;
    tick();

    // write-back and issue to r2 in the same cycle
    in_valid = 1'b1; inst = mk(OP_ADD, 0, 2, 0, 16'h0);
    wb = 1'b1; wb_r = 4'd2; wb_data = 32'hCAFE;
    #1 chk("coll_ready", 32'(in_ready), 1);
    tick();
    wb = 1'b0;
    chk("coll_rd_value", rd_value, 32'hCAFE);
    out_ready = 1'b0; inst = mk(OP_ADD, 0, 11, 2, 16'h0);
    #1 chk("coll_busy_stall", 32'(stall), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 chk("coll_post_flush_ready", 32'(in_ready), 1);
    tick();
    chk("coll_r2_value", rs_value, 32'hCAFE);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // non-writing classes leave the scoreboard alone
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inst = mk(tbl_op[i], 1, 0, 0, 16'h0);
      #1 chk("nw_ready", 32'(in_ready), 1);
      tick();
      chk("nw_ctrl", 32'(ctrl), 32'(tbl_ctrl[i]));
      chk("nw_opcode", 32'(opcode), 32'(tbl_op[i]));
    end
    chk("nw_immf", 32'(immf), 1);
    inst = mk(7'b0010010, 0, 14, 0, 16'h0);
    tick();
    chk("logic_ctrl", 32'(ctrl), 32'h20);
    inst = mk(7'b0010110, 0, 15, 0, 16'h0);
    #1 chk("set_ready", 32'(in_ready), 1);
    tick();
    chk("set_ctrl", 32'(ctrl), 0);
    inst = mk(OP_ADD, 0, 0, 15, 16'h0);
    #1 chk("set_busy_stall", 32'(stall), 1);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
